// File: rtl/vga_ctrl_pkg.sv
// Shared types and defaults for the VGA view controller.
// Mode encoding, frame geometry and the offset clamp helper.
package vga_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SAVER  = 2'd2
    } mode_t;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int OFF_W = 10;

    typedef logic [OFF_W-1:0]      off_t;
    typedef logic signed [OFF_W:0] soff_t;

    // Saturate a signed candidate offset into [0, hi].
    function automatic off_t clamp_off(soff_t v, off_t hi);
        if (v < 0)
            return '0;
        if (v > $signed({1'b0, hi}))
            return hi;
        return off_t'(v);
    endfunction

endpackage

// File: rtl/vga_view_ctrl_if.sv
// Board-side bundle of the view controller.
// master: board/bench drives inputs; slave: controller drives view outputs.
interface vga_view_ctrl_if;
    import vga_ctrl_pkg::*;

    logic [3:0] radio;
    logic       sw_left;
    logic       sw_right;
    logic       sw_up;
    logic       sw_down;
    logic       btn_return;
    logic       screensaver;
    logic       stretch;
    logic       frame_start;
    logic [1:0] img_sel;
    off_t       x_off;
    off_t       y_off;
    logic       scale;
    logic [1:0] mode;
    logic       blank;

    modport master (
        output radio, sw_left, sw_right, sw_up, sw_down,
        output btn_return, screensaver, stretch, frame_start,
        input  img_sel, x_off, y_off, scale, mode, blank
    );

    modport slave (
        input  radio, sw_left, sw_right, sw_up, sw_down,
        input  btn_return, screensaver, stretch, frame_start,
        output img_sel, x_off, y_off, scale, mode, blank
    );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse.
// Ports: clk, rst (async active-low), d (raw level), pulse (1-cycle).
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= d;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/vga_view_ctrl.sv
// View-parameter sequencer: buttons/switches -> frame-gated offsets, scale, mode.
// Ports: clk, rst (async active-low), bus (vga_view_ctrl_if.slave).
module vga_view_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int P_H_ACT    = H_ACT,
    parameter int P_V_ACT    = V_ACT,
    parameter int P_IMG_W    = IMG_W,
    parameter int P_IMG_H    = IMG_H,
    parameter int STEP       = 8,
    parameter int SAVER_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    vga_view_ctrl_if.slave  bus
);

    localparam off_t  XMAX1 = off_t'(P_H_ACT - P_IMG_W);
    localparam off_t  XMAX2 = off_t'(P_H_ACT - 2 * P_IMG_W);
    localparam off_t  YMAX1 = off_t'(P_V_ACT - P_IMG_H);
    localparam off_t  YMAX2 = off_t'(P_V_ACT - 2 * P_IMG_H);
    localparam soff_t ST    = soff_t'(STEP);
    localparam soff_t SS    = soff_t'(SAVER_STEP);

    logic [6:0] raw, pls;
    assign raw = {bus.stretch, bus.screensaver, bus.btn_return,
                  bus.sw_down, bus.sw_up, bus.sw_right, bus.sw_left};

    for (genvar i = 0; i < 7; i++) begin : g_btn
        btn_sync_edge u_sync (
            .clk   (clk),
            .rst   (rst),
            .d     (raw[i]),
            .pulse (pls[i])
        );
    end

    // Same-cycle priority: return > screensaver > stretch > arrows.
    logic p_ret, p_ss, p_st, arw_ok;
    assign p_ret  = pls[4];
    assign p_ss   = pls[5] & ~pls[4];
    assign p_st   = pls[6] & ~pls[5] & ~pls[4];
    assign arw_ok = ~|pls[6:4];

    mode_t      mode;
    off_t       x_off, y_off;
    logic       scale, blank;
    logic [1:0] img_sel;
    logic       pend_l, pend_r, pend_u, pend_d, pend_st, pend_ret;
    logic       dx_neg, dy_neg;

    logic [1:0] sel;
    always_comb begin
        sel = 2'd0;
        priority case (1'b1)
            bus.radio[3]: sel = 2'd3;
            bus.radio[2]: sel = 2'd2;
            bus.radio[1]: sel = 2'd1;
            default:      sel = 2'd0;
        endcase
    end

    // Candidate offsets for the next frame, bounded by the post-toggle size.
    logic  nscale, dx_flip, dy_flip;
    off_t  xmax, ymax, x_nx, y_nx;
    soff_t x_mv, y_mv, x_sv, y_sv;
    always_comb begin
        nscale  = scale ^ pend_st;
        xmax    = nscale ? XMAX2 : XMAX1;
        ymax    = nscale ? YMAX2 : YMAX1;
        x_mv    = $signed({1'b0, x_off});
        y_mv    = $signed({1'b0, y_off});
        if (pend_r && !pend_l) x_mv = x_mv + ST;
        if (pend_l && !pend_r) x_mv = x_mv - ST;
        if (pend_d && !pend_u) y_mv = y_mv + ST;
        if (pend_u && !pend_d) y_mv = y_mv - ST;
        x_sv    = $signed({1'b0, x_off}) + (dx_neg ? -SS : SS);
        y_sv    = $signed({1'b0, y_off}) + (dy_neg ? -SS : SS);
        dx_flip = (x_sv < 0) || (x_sv > $signed({1'b0, xmax}));
        dy_flip = (y_sv < 0) || (y_sv > $signed({1'b0, ymax}));
        if (pend_ret) begin
            x_nx = '0;
            y_nx = '0;
        end else if (mode == SAVER) begin
            x_nx = clamp_off(x_sv, xmax);
            y_nx = clamp_off(y_sv, ymax);
        end else begin
            x_nx = clamp_off(x_mv, xmax);
            y_nx = clamp_off(y_mv, ymax);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode     <= IDLE;
            x_off    <= '0;
            y_off    <= '0;
            scale    <= 1'b0;
            blank    <= 1'b1;
            img_sel  <= 2'd0;
            pend_l   <= 1'b0;
            pend_r   <= 1'b0;
            pend_u   <= 1'b0;
            pend_d   <= 1'b0;
            pend_st  <= 1'b0;
            pend_ret <= 1'b0;
            dx_neg   <= 1'b0;
            dy_neg   <= 1'b0;
        end else begin
            if (bus.radio != 4'd0)
                img_sel <= sel;
            if (bus.radio == 4'd0) begin
                mode     <= IDLE;
                blank    <= 1'b1;
                pend_l   <= 1'b0;
                pend_r   <= 1'b0;
                pend_u   <= 1'b0;
                pend_d   <= 1'b0;
                pend_st  <= 1'b0;
                pend_ret <= 1'b0;
            end else if (mode == IDLE) begin
                mode  <= MANUAL;
                blank <= 1'b0;
                x_off <= '0;
                y_off <= '0;
            end else begin
                if (bus.frame_start) begin
                    x_off    <= x_nx;
                    y_off    <= y_nx;
                    scale    <= nscale;
                    pend_l   <= 1'b0;
                    pend_r   <= 1'b0;
                    pend_u   <= 1'b0;
                    pend_d   <= 1'b0;
                    pend_st  <= 1'b0;
                    pend_ret <= 1'b0;
                    if (mode == SAVER && !pend_ret) begin
                        if (dx_flip) dx_neg <= ~dx_neg;
                        if (dy_flip) dy_neg <= ~dy_neg;
                    end
                end
                if (p_ret || p_ss || mode == SAVER) begin
                    pend_l <= 1'b0;
                    pend_r <= 1'b0;
                    pend_u <= 1'b0;
                    pend_d <= 1'b0;
                end
                if (p_ret) begin
                    pend_ret <= 1'b1;
                    mode     <= MANUAL;
                end else if (p_ss) begin
                    if (mode == SAVER) begin
                        mode <= MANUAL;
                    end else begin
                        mode   <= SAVER;
                        dx_neg <= 1'b0;
                        dy_neg <= 1'b0;
                    end
                end else if (p_st) begin
                    pend_st <= 1'b1;
                end else if (arw_ok && mode == MANUAL) begin
                    if (pls[0]) pend_l <= 1'b1;
                    if (pls[1]) pend_r <= 1'b1;
                    if (pls[2]) pend_u <= 1'b1;
                    if (pls[3]) pend_d <= 1'b1;
                end
            end
        end
    end

    assign bus.mode    = mode;
    assign bus.x_off   = x_off;
    assign bus.y_off   = y_off;
    assign bus.scale   = scale;
    assign bus.blank   = blank;
    assign bus.img_sel = img_sel;

endmodule

// File: tb/tb_vga_view_ctrl.sv
// Directed bench for vga_view_ctrl.
// Linear step sequence, immediate-assertion checks, one summary line.
module tb_vga_view_ctrl;

    localparam logic [6:0] B_L   = 7'b0000001;
    localparam logic [6:0] B_R   = 7'b0000010;
    localparam logic [6:0] B_D   = 7'b0001000;
    localparam logic [6:0] B_RET = 7'b0010000;
    localparam logic [6:0] B_SS  = 7'b0100000;
    localparam logic [6:0] B_ST  = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] btn;
    int         checks = 0;
    int         errors = 0;

    vga_view_ctrl_if vif ();

    assign vif.sw_left     = btn[0];
    assign vif.sw_right    = btn[1];
    assign vif.sw_up       = btn[2];
    assign vif.sw_down     = btn[3];
    assign vif.btn_return  = btn[4];
    assign vif.screensaver = btn[5];
    assign vif.stretch     = btn[6];

    vga_view_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [6:0] m, input int hold);
        @(negedge clk);
        btn = m;
        repeat (hold) @(negedge clk);
        btn = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        vif.frame_start = 1'b1;
        @(negedge clk);
        vif.frame_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_xy(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(vif.x_off), 32'(x));
        chk({tag, "_y"}, 32'(vif.y_off), 32'(y));
    endtask

    initial begin
        rst             = 1'b0;
        btn             = '0;
        vif.radio       = 4'd0;
        vif.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        chk_xy("rst", 0, 0);
        chk("rst_scale", 32'(vif.scale), 0);
        chk("rst_mode", 32'(vif.mode), 0);
        chk("rst_blank", 32'(vif.blank), 1);

        rst       = 1'b1;
        vif.radio = 4'b1000;
        repeat (2) @(negedge clk);
        chk("wake_mode", 32'(vif.mode), 1);
        chk("wake_sel", 32'(vif.img_sel), 3);
        chk("wake_blank", 32'(vif.blank), 0);
        vif.radio = 4'b0110;
        @(negedge clk);
        chk("radio_hi_bit", 32'(vif.img_sel), 2);
        vif.radio = 4'b1000;
        @(negedge clk);

        press(B_R, 100);
        chk("no_frame_yet", 32'(vif.x_off), 0);
        frame();
        chk("right1", 32'(vif.x_off), 8);
        press(B_R, 3);
        press(B_R, 3);
        frame();
        chk("right_twice", 32'(vif.x_off), 16);
        press(B_L | B_R, 3);
        frame();
        chk("left_right", 32'(vif.x_off), 16);
        press(B_L, 3);
        frame();
        chk("left1", 32'(vif.x_off), 8);
        press(B_L, 3);
        frame();
        chk("left2", 32'(vif.x_off), 0);
        press(B_L, 3);
        frame();
        chk("left_sat0", 32'(vif.x_off), 0);

        for (int i = 0; i < 59; i++) begin
            press(B_R | B_D, 2);
            frame();
        end
        chk_xy("walk", 472, 360);
        press(B_R, 2);
        frame();
        chk("right_max", 32'(vif.x_off), 480);
        press(B_R, 2);
        frame();
        chk("right_sat", 32'(vif.x_off), 480);
        press(B_ST, 2);
        chk("st_no_frame", 32'(vif.scale), 0);
        frame();
        chk("st_scale", 32'(vif.scale), 1);
        chk_xy("st_clamp", 320, 240);

        press(B_RET, 2);
        frame();
        chk_xy("ret", 0, 0);
        chk("ret_scale", 32'(vif.scale), 1);
        press(B_ST, 2);
        frame();
        chk("unstretch", 32'(vif.scale), 0);

        press(B_SS, 2);
        chk("saver_mode", 32'(vif.mode), 2);
        repeat (3) frame();
        chk_xy("saver3", 3, 3);
        press(B_L, 2);
        frame();
        chk_xy("saver_left_ign", 4, 4);
        press(B_SS, 2);
        chk("saver_off", 32'(vif.mode), 1);
        for (int i = 0; i < 60; i++) begin
            press(B_R, 2);
            frame();
        end
        chk_xy("to_edge", 480, 4);
        press(B_SS, 2);
        frame();
        chk("bounce_clamp", 32'(vif.x_off), 480);
        frame();
        chk_xy("bounce_back", 479, 6);

        press(B_RET, 2);
        chk("ret_to_manual", 32'(vif.mode), 1);
        frame();
        for (int i = 0; i < 6; i++) begin
            press(B_R, 2);
            frame();
        end
        press(B_SS, 2);
        repeat (50) frame();
        chk_xy("pre_simul", 98, 50);
        press(B_RET | B_SS | B_L, 2);
        chk("simul_mode", 32'(vif.mode), 1);
        chk("simul_hold", 32'(vif.x_off), 98);
        frame();
        chk_xy("simul_ret", 0, 0);
        frame();
        chk_xy("simul_noleft", 0, 0);

        vif.radio = 4'd0;
        @(negedge clk);
        chk("radio0_mode", 32'(vif.mode), 0);
        chk("radio0_blank", 32'(vif.blank), 1);
        vif.radio = 4'b1000;
        repeat (2) @(negedge clk);
        chk("radio_back", 32'(vif.mode), 1);

        press(B_SS, 2);
        repeat (3) frame();
        chk_xy("pre_rst", 3, 3);
        press(B_ST, 2);
        rst = 1'b0;
        #1;
        chk_xy("mid_rst", 0, 0);
        chk("mid_rst_mode", 32'(vif.mode), 0);
        chk("mid_rst_blank", 32'(vif.blank), 1);
        chk("mid_rst_sel", 32'(vif.img_sel), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_mode", 32'(vif.mode), 1);
        frame();
        chk("rel_scale", 32'(vif.scale), 0);
        chk_xy("rel", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
